// File: rtl/status_reporter.sv
// status_reporter: snapshots sticky status flags, sends a 3-byte frame
// (header, status, checksum) and acks exactly the reported flags afterwards.
module status_reporter #(
    parameter int          N_FLAGS = 4,
    parameter logic [7:0]  HEADER  = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_FLAGS-1:0] status,
    input  logic               force_report,
    output logic [N_FLAGS-1:0] ack,
    output logic [7:0]         tx_data,
    output logic               tx_rdy,
    input  logic               tx_ack,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, HDR, STAT, CHK, ACKS} state_t;
    state_t             state, state_nxt;
    logic [N_FLAGS-1:0] snap;
    logic               pend;
    logic               start;
    logic               xfer;
    logic [7:0]         stat_byte;
    assign stat_byte = 8'(snap);
    assign start     = (state == IDLE) && (|status || force_report || pend);
    assign xfer      = tx_rdy && tx_ack;
    assign busy      = state != IDLE;
    // A force arriving mid-frame is held until the next IDLE evaluation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            snap  <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) snap <= status;
            pend  <= start ? 1'b0 : (pend | (force_report && state != IDLE));
        end
    end
    always_comb begin
        state_nxt = state;
        tx_rdy    = 1'b0;
        tx_data   = 8'h00;
        ack       = '0;
        case (state)
            IDLE: state_nxt = start ? HDR : IDLE;
            HDR: begin
                tx_rdy    = 1'b1;
                tx_data   = HEADER;
                state_nxt = xfer ? STAT : HDR;
            end
            STAT: begin
                tx_rdy    = 1'b1;
                tx_data   = stat_byte;
                state_nxt = xfer ? CHK : STAT;
            end
            CHK: begin
                tx_rdy    = 1'b1;
                tx_data   = HEADER ^ stat_byte;
                state_nxt = xfer ? ACKS : CHK;
            end
            ACKS: begin
                ack       = snap;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_status_reporter.sv
// tb_status_reporter: directed frames against a sticky-flag model, both widths.
module tb_status_reporter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] st4 = '0, set4 = '0, ack4;
    logic [7:0] st8 = '0, set8 = '0, ack8;
    logic       force_report = 1'b0, tx_ack = 1'b0;
    logic [7:0] d4, d8;
    logic       r4, r8, b4, b8;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    status_reporter dut4 (
        .clk(clk), .rst(rst), .status(st4), .force_report(force_report),
        .ack(ack4), .tx_data(d4), .tx_rdy(r4), .tx_ack(tx_ack), .busy(b4)
    );
    status_reporter #(.N_FLAGS(8), .HEADER(8'h00)) dut8 (
        .clk(clk), .rst(rst), .status(st8), .force_report(1'b0),
        .ack(ack8), .tx_data(d8), .tx_rdy(r8), .tx_ack(tx_ack), .busy(b8)
    );

    // sticky status bits: set by pulses, cleared by ack at the same edge
    always @(posedge clk) begin
        st4 <= (st4 & ~ack4) | set4;
        st8 <= (st8 & ~ack8) | set8;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse4(input logic [3:0] v);
        set4 = v;
        @(negedge clk);
        set4 = '0;
    endtask

    task automatic wait_rdy(input bit w);
        int n = 0;
        while (!(w ? r8 : r4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("start", w ? r8 : r4, 1);
    endtask

    task automatic recv(input bit w, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] ackx,
                        input int stall, input logic [3:0] late);
        logic [7:0] bytes [3];
        bytes = '{b0, b1, b2};
        wait_rdy(w);
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < stall; s++) begin
                tx_ack = 1'b0;
                check("hold", w ? d8 : d4, bytes[i]);
                check("hold_rdy", w ? r8 : r4, 1);
                @(negedge clk);
            end
            check("byte", w ? d8 : d4, bytes[i]);
            check("rdy", w ? r8 : r4, 1);
            tx_ack = 1'b1;
            if (i == 1) set4 = late;
            @(negedge clk);
            tx_ack = 1'b0;
            set4 = '0;
        end
        check("ack", w ? ack8 : {4'h0, ack4}, ackx);
        check("rdy_acks", w ? r8 : r4, 0);
        check("busy_acks", w ? b8 : b4, 1);
        @(negedge clk);
        check("ack_once", w ? ack8 : {4'h0, ack4}, 0);
        check("idle_busy", w ? b8 : b4, 0);
    endtask

    initial begin
        bit any;
        repeat (2) @(negedge clk);
        check("rst_rdy", r4, 0);
        check("rst_data", d4, 0);
        check("rst_ack", ack4, 0);
        check("rst_busy", b4, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_quiet", b4, 0);
        // basic frame
        pulse4(4'b0101);
        recv(0, 8'hA5, 8'h05, 8'hA0, 8'h05, 0, 4'h0);
        check("basic_rdy_after", r4, 0);
        // stalls on every byte
        pulse4(4'b1000);
        recv(0, 8'hA5, 8'h08, 8'hAD, 8'h08, 3, 4'h0);
        // late flag rises during STAT and goes into a second frame
        pulse4(4'b0001);
        recv(0, 8'hA5, 8'h01, 8'hA4, 8'h01, 0, 4'b0100);
        recv(0, 8'hA5, 8'h04, 8'hA1, 8'h04, 0, 4'h0);
        // forced empty frame plus one merged force while busy
        force_report = 1'b1;
        @(negedge clk);
        force_report = 1'b0;
        check("force_hdr", r4, 1);
        force_report = 1'b1;
        @(negedge clk);
        force_report = 1'b0;
        recv(0, 8'hA5, 8'h00, 8'hA5, 8'h00, 0, 4'h0);
        recv(0, 8'hA5, 8'h00, 8'hA5, 8'h00, 0, 4'h0);
        any = 1'b0;
        repeat (10) begin
            @(negedge clk);
            any |= r4;
        end
        check("no_extra", any, 0);
        // async reset in CHK abandons the frame
        pulse4(4'b0011);
        wait_rdy(0);
        tx_ack = 1'b1;
        repeat (2) @(negedge clk);
        tx_ack = 1'b0;
        check("chk_byte", d4, 8'hA6);
        #2 rst = 1'b0;
        #1;
        check("arst_rdy", r4, 0);
        check("arst_data", d4, 0);
        check("arst_ack", ack4, 0);
        check("arst_busy", b4, 0);
        @(negedge clk);
        check("arst_ack2", ack4, 0);
        check("arst_status", st4, 4'b0011);
        rst = 1'b1;
        recv(0, 8'hA5, 8'h03, 8'hA6, 8'h03, 0, 4'h0);
        // 8-flag instance with zero header
        set8 = 8'hFF;
        @(negedge clk);
        set8 = 8'h00;
        recv(1, 8'h00, 8'hFF, 8'hFF, 8'hFF, 0, 4'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/status_reporter.md
# status_reporter

Downstream consumer of the tx_protocol status flags. Watches a vector of sticky status bits, and when any is set (or a report is forced) snapshots them. It then transmits a 3-byte status frame (header, status byte, checksum) over the tx byte handshake. Once the frame is fully accepted, it acknowledges exactly the flags that were reported, so each status bit is cleared only after its event has left the device.

## Interface
- N_FLAGS, default 4: number of status flags; legal range 1..8.
- HEADER, default 8'hA5: first byte of every status frame.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
- status  input  N_FLAGS  current levels of the status bits.
- force_report  input  1  single-cycle request to send a frame even with no flag set.
- ack  output  N_FLAGS  one-cycle clear pulses back to the status bits.
- tx_data  output  8  frame byte offered to the tx path.
- tx_rdy  output  1  tx_data valid.
- tx_ack  input  1  sink accepts tx_data; a transfer occurs on a cycle with tx_rdy && tx_ack.
- busy  output  1  high whenever state != IDLE.

## Operation
- Reset values: state IDLE; ack=0; tx_rdy=0; tx_data=8'h00; busy=0; snapshot=0; pending force cleared.
- force_report is latched into a pending bit when it arrives outside IDLE, and is consumed at the next IDLE evaluation. Requests are never lost; multiple requests merge into one frame.
- State IDLE:
  - If |status or force_report or force pending: register snap <= status and clear pending force.
  - Go to HDR.
  - Otherwise stay in IDLE.
- State HDR: tx_rdy=1, tx_data=HEADER. On transfer, go to STAT.
- State STAT: tx_rdy=1, tx_data={(8-N_FLAGS) zeros, snap}. On transfer, go to CHK.
- State CHK: tx_rdy=1, tx_data=HEADER ^ status byte. On transfer, go to ACKS.
- State ACKS:
  - tx_rdy=0; ack=snap for exactly one cycle; go to IDLE.
  - ack is all-zero for a forced frame with an empty snapshot.
- Only snapshotted flags are acked. A flag that rises after the snapshot stays set and is reported in the next frame.
- Flags that drop during a frame (external clear) are still reported as snapshotted.
- tx_data and tx_rdy hold stable while tx_rdy=1 and tx_ack=0. The sink may stall indefinitely.
- The status input is ignored outside IDLE.
- Async reset mid-frame:
  - Frame is abandoned and no ack is issued.
  - The status bits keep their values (unless also reset) and are re-reported after reset.

## Timing
- Snapshot to first byte: IDLE sample at edge k; tx_rdy=1 with HEADER during cycle k+1.
- With tx_ack tied high, bytes are transferred in cycles k+1, k+2 and k+3, and ack pulses in cycle k+4.
- Back in IDLE at cycle k+5. IDLE can start a new frame at that cycle; minimum frame period is 5 cycles.
- ack at cycle c clears the status bit at edge c (registered in the status bit). The IDLE sample at cycle c+1 therefore sees cleared flags, and no duplicate frame is sent.
- Each tx_ack-low cycle in HDR/STAT/CHK adds exactly one cycle of latency.
- tx_ack while tx_rdy=0 is ignored.
- busy rises the cycle after the snapshot edge and falls in the cycle after ACKS.

## Test plan
- **Basic frame.** N_FLAGS=4, status=4'b0101, tx_ack=1 → bytes A5, 05, A0 on consecutive cycles. Then ack=4'b0101 for one cycle, then IDLE with tx_rdy=0.
- **Stall.** status=4'b1000, tx_ack low 3 cycles in each byte state → each byte held stable until accepted. Bytes A5, 08, AD; ack=4'b1000 exactly once.
- **Late flag.**
  - status=4'b0001, then bit 2 rises while in STAT → first frame status byte 01 and ack=4'b0001 only.
  - A second frame follows with status byte 04 (bit 0 already cleared) and ack=4'b0100.
- **Force.** status=0, force_report pulse → frame A5, 00, A5 with ack=0. A force pulse during a busy frame → exactly one additional frame after it.
- **Reset mid-frame.** rst low during CHK, status held 4'b0011 → all outputs 0 immediately and no ack. After release, a fresh frame A5, 03, A6 is sent and acked.
- **Width edge.** N_FLAGS=8, status=8'hFF, HEADER=8'h00 → bytes 00, FF, FF and ack=8'hFF.
